fft_bfly_pipe: RTL and testbench

- Parametrised, handshaked radix-2 DIT butterfly pipeline; successor to the fixed single-butterfly FFT pipe.
- Sits between the dual-port sample RAM read ports and write-back ports of the FFT engine.
- Takes a per-butterfly twiddle input, a configurable multiplier depth, optional per-stage divide-by-2 scaling, and saturation with a sticky overflow flag.
- Carries valid and write addresses alongside the data so write-back stays aligned at any latency.

---
 rtl/fft_bfly_pipe.sv | 162 ++++++++++++++++
 tb/tb_fft_bfly_pipe.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_bfly_pipe.sv
// Radix-2 DIT butterfly pipeline: A +/- W*B with rounding, optional halving and
// saturation. Valid, addresses and scale ride a shift chain matched to the multiplier.
module fft_bfly_pipe #(
  parameter int WORD_SIZE  = 74,
  parameter int ADDR_SIZE  = 5,
  parameter int FRAC_BITS  = 18,
  parameter int MUL_STAGES = 2
) (
  input  logic                 i_CLK,
  input  logic                 i_RST_N,
  input  logic                 i_valid,
  input  logic [WORD_SIZE-1:0] i_rddata_A,
  input  logic [WORD_SIZE-1:0] i_rddata_B,
  input  logic [ADDR_SIZE-1:0] i_rdaddr_A,
  input  logic [ADDR_SIZE-1:0] i_rdaddr_B,
  input  logic [WORD_SIZE-1:0] i_twiddle,
  input  logic                 i_scale,
  input  logic                 i_clr_ovf,
  output logic                 o_valid,
  output logic [WORD_SIZE-1:0] o_wrdata_A,
  output logic [WORD_SIZE-1:0] o_wrdata_B,
  output logic [ADDR_SIZE-1:0] o_wraddr_A,
  output logic [ADDR_SIZE-1:0] o_wraddr_B,
  output logic                 o_busy,
  output logic                 o_ovf
);
  localparam int HALF = WORD_SIZE / 2;
  localparam int PW   = 2 * HALF;
  localparam logic signed [PW:0]     RND  = {{PW{1'b0}}, 1'b1} << (FRAC_BITS - 1);
  localparam logic signed [HALF+1:0] SMAX = {3'b000, {(HALF-1){1'b1}}};
  localparam logic signed [HALF+1:0] SMIN = {3'b111, {(HALF-1){1'b0}}};
  localparam logic signed [HALF+1:0] ONE  = {{(HALF+1){1'b0}}, 1'b1};

  typedef struct packed {
    logic [WORD_SIZE-1:0] a;
    logic [ADDR_SIZE-1:0] addr_a;
    logic [ADDR_SIZE-1:0] addr_b;
    logic                 scale;
  } side_t;

  logic [MUL_STAGES:0]    vld_pipe;
  side_t                  side_pipe [0:MUL_STAGES];
  logic [WORD_SIZE-1:0]   b_q, w_q;
  logic signed [HALF-1:0] wr, wi, br, bi;
  logic signed [PW-1:0]   m_rr, m_ii, m_ri, m_ir;
  logic signed [PW:0]     pr_full, pi_full;
  logic signed [HALF:0]   pr_c, pi_c, pr_m, pi_m;

  assign wr = w_q[WORD_SIZE-1:HALF];
  assign wi = w_q[HALF-1:0];
  assign br = b_q[WORD_SIZE-1:HALF];
  assign bi = b_q[HALF-1:0];

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      vld_pipe <= '0;
      b_q      <= '0;
      w_q      <= '0;
      m_rr     <= '0;
      m_ii     <= '0;
      m_ri     <= '0;
      m_ir     <= '0;
      for (int k = 0; k <= MUL_STAGES; k++) side_pipe[k] <= '0;
    end else begin
      vld_pipe     <= {vld_pipe[MUL_STAGES-1:0], i_valid};
      side_pipe[0] <= {i_rddata_A, i_rdaddr_A, i_rdaddr_B, i_scale};
      for (int k = 1; k <= MUL_STAGES; k++) side_pipe[k] <= side_pipe[k-1];
      b_q  <= i_rddata_B;
      w_q  <= i_twiddle;
      m_rr <= PW'(wr) * PW'(br);
      m_ii <= PW'(wi) * PW'(bi);
      m_ri <= PW'(wr) * PW'(bi);
      m_ir <= PW'(wi) * PW'(br);
    end
  end

  // Round half-up back to the sample grid; the extra bit absorbs |W| up to 2.0.
  assign pr_full = (PW+1)'(m_rr) - (PW+1)'(m_ii);
  assign pi_full = (PW+1)'(m_ri) + (PW+1)'(m_ir);
  assign pr_c    = (HALF+1)'((pr_full + RND) >>> FRAC_BITS);
  assign pi_c    = (HALF+1)'((pi_full + RND) >>> FRAC_BITS);

  generate
    if (MUL_STAGES == 1) begin : g_p1
      assign pr_m = pr_c;
      assign pi_m = pi_c;
    end else begin : g_pn
      logic signed [HALF:0] pr_d [1:MUL_STAGES-1];
      logic signed [HALF:0] pi_d [1:MUL_STAGES-1];
      always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
          for (int k = 1; k < MUL_STAGES; k++) begin
            pr_d[k] <= '0;
            pi_d[k] <= '0;
          end
        end else begin
          pr_d[1] <= pr_c;
          pi_d[1] <= pi_c;
          for (int k = 2; k < MUL_STAGES; k++) begin
            pr_d[k] <= pr_d[k-1];
            pi_d[k] <= pi_d[k-1];
          end
        end
      end
      assign pr_m = pr_d[MUL_STAGES-1];
      assign pi_m = pi_d[MUL_STAGES-1];
    end
  endgenerate

  // Returns {saturated, value}.
  function automatic logic [HALF:0] sat_fin(input logic signed [HALF+1:0] v, input logic sc);
    logic signed [HALF+1:0] t;
    t = sc ? ((v + ONE) >>> 1) : v;
    if (t > SMAX) return {1'b1, SMAX[HALF-1:0]};
    if (t < SMIN) return {1'b1, SMIN[HALF-1:0]};
    return {1'b0, t[HALF-1:0]};
  endfunction

  logic signed [HALF-1:0] ar, ai;
  logic signed [HALF+1:0] s_r, s_i, d_r, d_i;
  logic [HALF:0]          fs_r, fs_i, fd_r, fd_i;
  logic                   sc_o, vld_o, sat_any;

  assign ar    = side_pipe[MUL_STAGES].a[WORD_SIZE-1:HALF];
  assign ai    = side_pipe[MUL_STAGES].a[HALF-1:0];
  assign sc_o  = side_pipe[MUL_STAGES].scale;
  assign vld_o = vld_pipe[MUL_STAGES];
  assign s_r   = (HALF+2)'(ar) + (HALF+2)'(pr_m);
  assign s_i   = (HALF+2)'(ai) + (HALF+2)'(pi_m);
  assign d_r   = (HALF+2)'(ar) - (HALF+2)'(pr_m);
  assign d_i   = (HALF+2)'(ai) - (HALF+2)'(pi_m);
  assign fs_r  = sat_fin(s_r, sc_o);
  assign fs_i  = sat_fin(s_i, sc_o);
  assign fd_r  = sat_fin(d_r, sc_o);
  assign fd_i  = sat_fin(d_i, sc_o);
  assign sat_any = fs_r[HALF] | fs_i[HALF] | fd_r[HALF] | fd_i[HALF];

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      o_valid    <= 1'b0;
      o_wrdata_A <= '0;
      o_wrdata_B <= '0;
      o_wraddr_A <= '0;
      o_wraddr_B <= '0;
      o_ovf      <= 1'b0;
    end else begin
      o_valid <= vld_o;
      if (vld_o) begin
        o_wrdata_A <= {fs_r[HALF-1:0], fs_i[HALF-1:0]};
        o_wrdata_B <= {fd_r[HALF-1:0], fd_i[HALF-1:0]};
        o_wraddr_A <= side_pipe[MUL_STAGES].addr_a;
        o_wraddr_B <= side_pipe[MUL_STAGES].addr_b;
      end
      // A fresh saturation beats a simultaneous clear.
      if (vld_o && sat_any) o_ovf <= 1'b1;
      else if (i_clr_ovf)   o_ovf <= 1'b0;
    end
  end

  assign o_busy = (|vld_pipe) | o_valid;

endmodule

// File: tb/tb_fft_bfly_pipe.sv
// Bench for fft_bfly_pipe: three instances (MUL_STAGES 1/2/4) share stimulus;
// directed vectors plus a cycle-by-cycle scoreboard driven by a wide-integer model.
module tb_fft_bfly_pipe;
  localparam int WS   = 74;
  localparam int AS   = 5;
  localparam int F    = 18;
  localparam int HALF = WS / 2;
  localparam int CW   = 3 + 2*WS + 2*AS;

  typedef logic signed [127:0] big_t;
  typedef logic [CW-1:0] cv_t;

  typedef struct {
    bit            vld;
    logic [WS-1:0] a, b, w;
    logic [AS-1:0] aa, ab;
    bit            sc;
    bit            clr;
  } op_t;

  typedef struct {
    longint ar, ai, br, bi, wr, wi;
    bit     sc;
    longint xar, xai, xbr, xbi;
    bit     xovf;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, i_valid, i_scale, i_clr;
  logic [WS-1:0] i_a, i_b, i_w;
  logic [AS-1:0] i_aa, i_ab;

  logic          o_valid_w [3];
  logic          o_busy_w  [3];
  logic          o_ovf_w   [3];
  logic [WS-1:0] o_da_w    [3];
  logic [WS-1:0] o_db_w    [3];
  logic [AS-1:0] o_aa_w    [3];
  logic [AS-1:0] o_ab_w    [3];

  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int MS = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
      fft_bfly_pipe #(.WORD_SIZE(WS), .ADDR_SIZE(AS), .FRAC_BITS(F), .MUL_STAGES(MS)) u_dut (
        .i_CLK(clk), .i_RST_N(rst_n), .i_valid(i_valid),
        .i_rddata_A(i_a), .i_rddata_B(i_b), .i_rdaddr_A(i_aa), .i_rdaddr_B(i_ab),
        .i_twiddle(i_w), .i_scale(i_scale), .i_clr_ovf(i_clr),
        .o_valid(o_valid_w[g]), .o_wrdata_A(o_da_w[g]), .o_wrdata_B(o_db_w[g]),
        .o_wraddr_A(o_aa_w[g]), .o_wraddr_B(o_ab_w[g]), .o_busy(o_busy_w[g]), .o_ovf(o_ovf_w[g])
      );
    end
  endgenerate

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input cv_t act, input cv_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic int lat(input int d);
    return (d == 0) ? 3 : ((d == 1) ? 4 : 6);
  endfunction

  function automatic big_t sx(input big_t x, input int bits);
    return (x <<< (128 - bits)) >>> (128 - bits);
  endfunction

  function automatic big_t hi(input logic [WS-1:0] w);
    return sx(big_t'(w[WS-1:HALF]), HALF);
  endfunction

  function automatic big_t lo(input logic [WS-1:0] w);
    return sx(big_t'(w[HALF-1:0]), HALF);
  endfunction

  function automatic logic [WS-1:0] pk(input big_t re, input big_t im);
    return {re[HALF-1:0], im[HALF-1:0]};
  endfunction

  function automatic big_t rs(input int bits);
    big_t r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return sx(r, bits);
  endfunction

  // Optional halving then clamp into the signed HALF-bit range.
  function automatic big_t fin_m(input big_t v, input bit sc, inout bit sat);
    big_t mx, mn, t;
    mx = (big_t'(1) <<< (HALF - 1)) - 1;
    mn = -(big_t'(1) <<< (HALF - 1));
    t  = sc ? ((v + 1) >>> 1) : v;
    if (t > mx) begin sat = 1; return mx; end
    if (t < mn) begin sat = 1; return mn; end
    return t;
  endfunction

  function automatic void bfly(input op_t o, output logic [WS-1:0] ra, output logic [WS-1:0] rb,
                               output bit sat);
    big_t pr, pi, sr, si, dr, di;
    pr  = hi(o.w) * hi(o.b) - lo(o.w) * lo(o.b);
    pi  = hi(o.w) * lo(o.b) + lo(o.w) * hi(o.b);
    pr  = sx((pr + (big_t'(1) <<< (F - 1))) >>> F, HALF + 1);
    pi  = sx((pi + (big_t'(1) <<< (F - 1))) >>> F, HALF + 1);
    sat = 0;
    sr  = fin_m(hi(o.a) + pr, o.sc, sat);
    si  = fin_m(lo(o.a) + pi, o.sc, sat);
    dr  = fin_m(hi(o.a) - pr, o.sc, sat);
    di  = fin_m(lo(o.a) - pi, o.sc, sat);
    ra  = pk(sr, si);
    rb  = pk(dr, di);
  endfunction

  // Scoreboard: history of sampled inputs; output at edge t is the op from edge t-L+1.
  op_t           hist [8];
  int            cyc = 16;
  logic          exp_v [3], exp_ovf [3], exp_busy [3];
  logic [WS-1:0] exp_a [3], exp_b [3];
  logic [AS-1:0] exp_aa [3], exp_ab [3];
  int            vcount [3];
  op_t           cur, oo;
  logic [WS-1:0] ra, rb;
  bit            sat;

  initial begin
    for (int k = 0; k < 8; k++) hist[k].vld = 0;
    for (int d = 0; d < 3; d++) begin
      exp_v[d] = 0; exp_ovf[d] = 0; exp_busy[d] = 0;
      exp_a[d] = '0; exp_b[d] = '0; exp_aa[d] = '0; exp_ab[d] = '0;
      vcount[d] = 0;
    end
  end

  always @(posedge clk) begin
    cur.vld = i_valid; cur.a = i_a; cur.b = i_b; cur.w = i_w;
    cur.aa = i_aa; cur.ab = i_ab; cur.sc = i_scale; cur.clr = i_clr;
    cyc++;
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) hist[k].vld = 0;
      for (int d = 0; d < 3; d++) begin
        exp_v[d] = 0; exp_ovf[d] = 0; exp_busy[d] = 0;
        exp_a[d] = '0; exp_b[d] = '0; exp_aa[d] = '0; exp_ab[d] = '0;
      end
    end else begin
      hist[cyc % 8] = cur;
      for (int d = 0; d < 3; d++) begin
        oo = hist[(cyc - lat(d) + 1) % 8];
        exp_v[d] = oo.vld;
        if (oo.vld) begin
          bfly(oo, ra, rb, sat);
          exp_a[d] = ra; exp_b[d] = rb; exp_aa[d] = oo.aa; exp_ab[d] = oo.ab;
        end else sat = 0;
        if (sat) exp_ovf[d] = 1;
        else if (cur.clr) exp_ovf[d] = 0;
        exp_busy[d] = 0;
        for (int k = 0; k < lat(d); k++) exp_busy[d] |= hist[(cyc - k) % 8].vld;
      end
    end
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("sb d%0d c%0d", d, cyc),
          {o_valid_w[d], o_busy_w[d], o_ovf_w[d], o_da_w[d], o_db_w[d], o_aa_w[d], o_ab_w[d]},
          {exp_v[d], exp_busy[d], exp_ovf[d], exp_a[d], exp_b[d], exp_aa[d], exp_ab[d]});
      if (o_valid_w[d]) vcount[d]++;
    end
  end

  vec_t vt [8];
  int   vc0 [3];
  int   first [3];
  int   k;

  task automatic put_rand(input logic [AS-1:0] aa, input logic [AS-1:0] ab);
    int m;
    m       = $urandom_range(37, 4);
    i_a     = pk(rs(m), rs(m));
    m       = $urandom_range(37, 4);
    i_b     = pk(rs(m), rs(m));
    i_w     = pk(rs(20), rs(20));
    i_scale = $urandom_range(1, 0) == 1;
    i_aa    = aa;
    i_ab    = ab;
  endtask

  initial begin
    vt[0] = '{100, 50, 10, -20, 262144, 0, 0, 110, 30, 90, 70, 0};
    vt[1] = '{0, 0, 1, 0, 0, 262144, 0, 0, 1, 0, -1, 0};
    vt[2] = '{0, 0, 3, 0, 131072, 0, 0, 2, 0, -2, 0, 0};
    vt[3] = '{0, 0, -3, 0, 131072, 0, 0, -1, 0, 1, 0, 0};
    vt[4] = '{3, -3, 0, 0, 262144, 0, 1, 2, -1, 2, -1, 0};
    vt[5] = '{64'sd68719476735, 0, 1, 0, 262144, 0, 0, 64'sd68719476735, 0, 64'sd68719476734, 0, 1};
    vt[6] = '{64'sd68719476735, 0, 1, 0, 262144, 0, 1, 64'sd34359738368, 0, 64'sd34359738367, 0, 0};
    vt[7] = '{-64'sd68719476736, 0, 1, 0, 262144, 0, 0, -64'sd68719476735, 0, -64'sd68719476736, 0, 1};

    rst_n = 0; i_valid = 0; i_scale = 0; i_clr = 0;
    i_a = '0; i_b = '0; i_w = '0; i_aa = '0; i_ab = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++)
      chk($sformatf("reset d%0d", d),
          cv_t'({o_valid_w[d], o_busy_w[d], o_ovf_w[d], o_da_w[d], o_db_w[d], o_aa_w[d], o_ab_w[d]}), '0);
    @(negedge clk) rst_n = 1;

    // Directed vectors on the MUL_STAGES=2 instance, exact latency 4.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); i_clr = 1; i_valid = 0;
      @(negedge clk); i_clr = 0; i_valid = 1;
      i_a = pk(vt[i].ar, vt[i].ai); i_b = pk(vt[i].br, vt[i].bi); i_w = pk(vt[i].wr, vt[i].wi);
      i_scale = vt[i].sc; i_aa = AS'(3 + i); i_ab = AS'(19 + i);
      @(negedge clk); i_valid = 0;
      repeat (2) @(posedge clk);
      #1 chk($sformatf("vec%0d early", i), cv_t'(o_valid_w[1]), cv_t'(1'b0));
      @(posedge clk);
      #1 chk($sformatf("vec%0d out", i),
             cv_t'({o_valid_w[1], o_da_w[1], o_db_w[1], o_aa_w[1], o_ab_w[1], o_ovf_w[1]}),
             cv_t'({1'b1, pk(vt[i].xar, vt[i].xai), pk(vt[i].xbr, vt[i].xbi),
                    AS'(3 + i), AS'(19 + i), vt[i].xovf}));
    end

    // Sticky overflow holds, then clears; a coincident saturation beats the clear.
    repeat (3) @(posedge clk);
    #1 chk("ovf hold", cv_t'(o_ovf_w[1]), cv_t'(1'b1));
    @(negedge clk) i_clr = 1;
    @(negedge clk) i_clr = 0;
    #0 chk("ovf clr", cv_t'(o_ovf_w[1]), cv_t'(1'b0));
    i_valid = 1; i_a = pk(-64'sd68719476736, 0); i_b = pk(1, 0); i_w = pk(262144, 0); i_scale = 0;
    @(negedge clk) i_valid = 0;
    @(negedge clk);
    @(negedge clk) i_clr = 1;
    @(posedge clk);
    #1 chk("ovf set wins", cv_t'({o_valid_w[1], o_ovf_w[1]}), cv_t'(2'b11));
    @(negedge clk) i_clr = 1;
    @(negedge clk) i_clr = 0;
    #0 chk("ovf clr2", cv_t'(o_ovf_w[1]), cv_t'(1'b0));

    // Streaming: 32 ops with valid pattern 1,1,0,1.
    repeat (8) @(negedge clk);
    for (int d = 0; d < 3; d++) vc0[d] = vcount[d];
    k = 0;
    for (int i = 0; k < 32; i++) begin
      if (i % 4 == 2) i_valid = 0;
      else begin
        i_valid = 1;
        put_rand(AS'(k), AS'(31 - k));
        k++;
      end
      @(negedge clk);
    end
    i_valid = 0;
    repeat (10) @(negedge clk);
    for (int d = 0; d < 3; d++)
      chk($sformatf("stream count d%0d", d), cv_t'(vcount[d] - vc0[d]), cv_t'(32));

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      i_valid = $urandom_range(9, 0) < 7;
      i_clr   = $urandom_range(19, 0) == 0;
      put_rand(AS'($urandom), AS'($urandom));
      @(negedge clk);
    end
    i_valid = 0; i_clr = 0;

    // Reset with three ops in flight.
    repeat (8) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      i_valid = 1;
      put_rand(AS'(i), AS'(i + 8));
      @(negedge clk);
    end
    i_valid = 0;
    for (int d = 0; d < 3; d++) chk($sformatf("busy pre-rst d%0d", d), cv_t'(o_busy_w[d]), cv_t'(1'b1));
    #2 rst_n = 0;
    #1;
    for (int d = 0; d < 3; d++)
      chk($sformatf("async rst d%0d", d),
          cv_t'({o_valid_w[d], o_busy_w[d], o_ovf_w[d], o_da_w[d], o_db_w[d], o_aa_w[d], o_ab_w[d]}), '0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (8) @(negedge clk);
    i_valid = 1;
    put_rand(AS'(5), AS'(21));
    @(negedge clk) i_valid = 0;
    for (int d = 0; d < 3; d++) first[d] = 0;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) if (o_valid_w[d] && first[d] == 0) first[d] = e;
    end
    for (int d = 0; d < 3; d++)
      chk($sformatf("post-rst latency d%0d", d), cv_t'(first[d] + 1), cv_t'(lat(d)));

    repeat (4) @(posedge clk);
    #2 $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
